// File: rtl/cic_pkg.sv
// Sizing helpers shared by the CIC decimator and its output stage.
package cic_pkg;
  localparam int N_MIN = 1;
  localparam int N_MAX = 6;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int acc_width(input int width, input int n, input int rate_max_log);
    return width + n * rate_max_log;
  endfunction

  // Bit growth of an N-stage CIC at rate r, rounded up to a whole shift.
  function automatic int gain_shift(input int r, input int n);
    return (r <= 1) ? 0 : n * clog2(r);
  endfunction
endpackage

// File: rtl/cic_round_sat.sv
// Final pipeline stage: round-half-up arithmetic shift, then saturate to OUT_W.
module cic_round_sat
  import cic_pkg::*;
#(
  parameter int IN_W    = 44,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IN_W-1:0]    data,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               valid,
  output logic [OUT_W-1:0]   result,
  output logic               result_valid
);
  localparam logic signed [IN_W:0] SAT_HI = (IN_W + 1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_LO = ~SAT_HI;

  logic signed [IN_W:0] widened;
  logic signed [IN_W:0] half;
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;
  logic [OUT_W-1:0]     saturated;

  // One guard bit keeps the rounding add from overflowing near full scale.
  always_comb begin
    widened = signed'({data[IN_W-1], data});
    half    = '0;
    if (shift != '0) half = (IN_W + 1)'(1) << (shift - SHIFT_W'(1));
    rounded = widened + half;
    shifted = rounded >>> shift;
    if (shifted > SAT_HI)      saturated = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) saturated = SAT_LO[OUT_W-1:0];
    else                       saturated = shifted[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= valid;
      if (valid) result <= saturated;
    end
  end
endmodule

// File: rtl/cic_decimator_p.sv
// N-stage CIC decimator with runtime rate, internal decimation counter and output strobe.
// stb_in qualifies data_in for one cycle; stb_out is a one-cycle pulse marking a new data_out; no backpressure.
module cic_decimator_p
  import cic_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int N            = 4,
  parameter int RATE_MAX_LOG = 7,
  parameter int RATE_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              stb_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              stb_out
);
  localparam int ACC_W   = acc_width(WIDTH, N, RATE_MAX_LOG);
  localparam int SHIFT_W = clog2(N * RATE_MAX_LOG + 1);
  localparam logic [RATE_W-1:0] R_MAX = RATE_W'(2 ** RATE_MAX_LOG);

  logic                clear;
  logic [RATE_W-1:0]   rate_eff;
  logic [RATE_W-1:0]   rate_l;
  logic [RATE_W-1:0]   count;
  logic                event_now;
  logic                ev_q;
  logic [SHIFT_W-1:0]  ev_shift;
  logic [ACC_W-1:0]    x_ext;
  logic [ACC_W-1:0]    integ     [N];
  logic [ACC_W-1:0]    comb_y    [N];
  logic [ACC_W-1:0]    comb_prev [N];
  logic [SHIFT_W-1:0]  comb_s    [N];
  logic                comb_v    [N];

  assign clear     = !rst_n || !enable;
  assign x_ext     = {{(ACC_W - WIDTH){data_in[WIDTH-1]}}, data_in};
  assign event_now = stb_in && (count == rate_l - RATE_W'(1));

  always_comb begin
    rate_eff = rate;
    if (rate == '0)         rate_eff = RATE_W'(1);
    else if (rate > R_MAX)  rate_eff = R_MAX;
  end

  // The rate is sampled continuously while cleared, so the value present on release governs the first period.
  always_ff @(posedge clk) begin
    if (clear) begin
      count  <= '0;
      rate_l <= rate_eff;
    end else if (stb_in) begin
      if (event_now) begin
        count  <= '0;
        rate_l <= rate_eff;
      end else begin
        count <= count + RATE_W'(1);
      end
    end
  end

  // The shift belongs to the period just ending, not to the newly latched rate.
  always_ff @(posedge clk) begin
    if (clear) begin
      ev_q     <= 1'b0;
      ev_shift <= '0;
    end else begin
      ev_q <= event_now;
      if (event_now) ev_shift <= SHIFT_W'(gain_shift(int'(rate_l), N));
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_int
    logic [ACC_W-1:0] addend;
    if (i == 0) begin : g_head
      assign addend = x_ext;
    end else begin : g_tail
      assign addend = integ[i-1];
    end
    always_ff @(posedge clk) begin
      if (clear)       integ[i] <= '0;
      else if (stb_in) integ[i] <= integ[i] + addend;
    end
  end

  // Each comb stage differences against its own input at the previous event.
  for (genvar k = 0; k < N; k++) begin : g_comb
    logic [ACC_W-1:0]   stage_x;
    logic [SHIFT_W-1:0] stage_s;
    logic               stage_v;
    if (k == 0) begin : g_head
      assign stage_x = integ[N-1];
      assign stage_s = ev_shift;
      assign stage_v = ev_q;
    end else begin : g_tail
      assign stage_x = comb_y[k-1];
      assign stage_s = comb_s[k-1];
      assign stage_v = comb_v[k-1];
    end
    always_ff @(posedge clk) begin
      if (clear) begin
        comb_v[k]    <= 1'b0;
        comb_y[k]    <= '0;
        comb_prev[k] <= '0;
        comb_s[k]    <= '0;
      end else begin
        comb_v[k] <= stage_v;
        if (stage_v) begin
          comb_y[k]    <= stage_x - comb_prev[k];
          comb_prev[k] <= stage_x;
          comb_s[k]    <= stage_s;
        end
      end
    end
  end

  cic_round_sat #(
    .IN_W   (ACC_W),
    .OUT_W  (WIDTH),
    .SHIFT_W(SHIFT_W)
  ) u_round_sat (
    .clk         (clk),
    .rst_n       (!clear),
    .data        (comb_y[N-1]),
    .shift       (comb_s[N-1]),
    .valid       (comb_v[N-1]),
    .result      (data_out),
    .result_valid(stb_out)
  );
endmodule

// File: tb/tb_cic_decimator_p.sv
// Scoreboard bench for cic_decimator_p against an arithmetic CIC reference model.
module tb_cic_decimator_p;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int RML   = 7;
  localparam int RW    = 8;
  localparam int ACC_W = WIDTH + N * RML;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             enable  = 1'b0;
  logic [RW-1:0]    rate    = 8'd8;
  logic [WIDTH-1:0] data_in = '0;
  logic             stb_in  = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             stb_out;

  cic_decimator_p #(.WIDTH(WIDTH), .N(N), .RATE_MAX_LOG(RML), .RATE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate(rate),
    .data_in(data_in), .stb_in(stb_in), .data_out(data_out), .stb_out(stb_out)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               due_q[$];
  int               checks = 0;
  int               errors = 0;

  // Reference model: accepted samples and integrator outputs at events since the last clear.
  longint hist[$];
  longint evs[$];
  int     m_cnt = 0;
  int     m_rl  = 1;

  task automatic check_val(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int eff_rate(input int rt);
    if (rt == 0) return 1;
    if (rt > (1 << RML)) return 1 << RML;
    return rt;
  endfunction

  function automatic int ceil_log2(input int r);
    int c = 0;
    while ((1 << c) < r) c++;
    return c;
  endfunction

  function automatic longint binom(input int n, input int k);
    longint c = 1;
    if (n < k || n < 0) return 0;
    for (int i = 1; i <= k; i++) c = c * (n - k + i) / i;
    return c;
  endfunction

  // N cascaded accumulators, each after the first seeing the previous one's registered value:
  // the last one holds sum_j C(k-j, N-1) * x_j after sample k.
  function automatic longint integrated();
    longint acc = 0;
    int k = hist.size() - 1;
    for (int j = 0; j <= k; j++) acc += binom(k - j, N - 1) * hist[j];
    return acc;
  endfunction

  // N-th difference over the event sequence, wrapped to ACC_W, then rounded and saturated.
  function automatic logic [WIDTH-1:0] decimated(input int r);
    longint y = 0;
    longint v;
    int m = evs.size() - 1;
    int s = N * ceil_log2(r);
    for (int i = 0; i <= N; i++) begin
      if (m - i >= 0) y += ((i % 2 == 0) ? 1 : -1) * binom(N, i) * evs[m - i];
    end
    v = (y <<< (64 - ACC_W)) >>> (64 - ACC_W);
    if (s > 0) v = (v + (longint'(1) <<< (s - 1))) >>> s;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return WIDTH'(v);
  endfunction

  task automatic model_step(input logic active, input int rt, input int x, input logic s);
    if (!active) begin
      hist.delete();
      evs.delete();
      m_cnt = 0;
      m_rl  = eff_rate(rt);
      while (due_q.size() > 0 && due_q[$] > cyc) begin
        void'(due_q.pop_back());
        void'(exp_q.pop_back());
      end
    end else if (s) begin
      hist.push_back(longint'(x));
      m_cnt++;
      if (m_cnt == m_rl) begin
        evs.push_back(integrated());
        exp_q.push_back(decimated(m_rl));
        due_q.push_back(cyc + N + 2);
        m_cnt = 0;
        m_rl  = eff_rate(rt);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic en, input int rt, input int x, input logic s);
    rst_n   = r;
    enable  = en;
    rate    = RW'(rt);
    data_in = WIDTH'(x);
    stb_in  = s;
    model_step(r && en, rt, x, s);
    @(posedge clk);
    #1;
    if (!(r && en)) begin
      check_val("clear_stb", longint'(stb_out), 0);
      check_val("clear_data", longint'($signed(data_out)), 0);
    end
  endtask

  task automatic idle(input int n, input int rt);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, rt, 0, 1'b0);
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] < cyc) begin
      check_val("missing_stb", cyc, due_q[0]);
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (stb_out) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_stb", longint'(stb_out), 0);
      end else begin
        check_val("stb_cycle", cyc, due_q.pop_front());
        check_val("stb_data", longint'($signed(data_out)), longint'($signed(exp_q.pop_front())));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8, int'($urandom_range(0, 2000)), (i % 2) == 0);

    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 8, 1000, 1'b1);
    idle(N + 4, 8);
    check_val("dc_r8", longint'($signed(data_out)), 1000);

    step(1'b1, 1'b0, 5, 0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 5, 1000, 1'b1);
    idle(N + 4, 5);
    check_val("dc_r5", longint'($signed(data_out)), 153);

    step(1'b1, 1'b0, 128, 0, 1'b0);
    for (int i = 0; i < 768; i++) step(1'b1, 1'b1, 128, 32767, 1'b1);
    idle(N + 4, 128);
    check_val("sat_pos", longint'($signed(data_out)), 32767);
    for (int i = 0; i < 768; i++) step(1'b1, 1'b1, 128, -32768, 1'b1);
    idle(N + 4, 128);
    check_val("sat_neg", longint'($signed(data_out)), -32768);

    step(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 0, rnd_sample(), 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1, rnd_sample(), 1'b1);
    idle(N + 4, 1);

    step(1'b1, 1'b0, 200, 0, 1'b0);
    for (int i = 0; i < 768; i++) step(1'b1, 1'b1, 200, 500, 1'b1);
    idle(N + 4, 200);
    check_val("rate_clamp", longint'($signed(data_out)), 500);

    step(1'b1, 1'b0, 4, 0, 1'b0);
    for (int i = 0; i < 72; i++) step(1'b1, 1'b1, 4, rnd_sample(), (i % 3) == 0);
    idle(N + 4, 4);

    step(1'b1, 1'b0, 8, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8, rnd_sample(), 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 4, rnd_sample(), 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 4, rnd_sample(), 1'b1);
    step(1'b1, 1'b0, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4, rnd_sample(), 1'b1);
    idle(N + 4, 4);

    rt = 3;
    step(1'b1, 1'b0, rt, 0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0)
        rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      step(1'b1, $urandom_range(0, 499) != 0, rt, rnd_sample(), 1'($urandom_range(0, 1)));
    end
    idle(N + 6, rt);

    check_val("pending_outputs", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
